// File: rtl/eth_pkg.sv
// Shared definitions for the MII receive front end: FSM encodings, MII framing
// nibbles and the nibble-to-buffer bit position helper.
package eth_pkg;

    typedef enum logic [2:0] {
        RX_IDLE     = 3'd0,
        RX_PREAMBLE = 3'd1,
        RX_PAYLOAD  = 3'd2,
        RX_DISCARD  = 3'd3
    } rx_state_e;

    localparam logic [3:0] MII_PREAMBLE_NIBBLE = 4'h5;
    localparam logic [3:0] MII_SFD_NIBBLE      = 4'hD;

    // Byte k sits at the top of the buffer first; its low nibble arrives first
    // and lands in the lower half of that byte.
    function automatic int nibble_lsb(input int frame_bits, input int nib_idx);
        return frame_bits - 8 * ((nib_idx / 2) + 1) + (((nib_idx % 2) != 0) ? 4 : 0);
    endfunction

endpackage

// File: rtl/eth_rx_drv_if.sv
// Frame hand-over channel between the MII receive front end and its consumer.
interface eth_rx_drv_if #(
    parameter int ETH_MAX_FRAME_SIZE = 256
);
    localparam int LEN_W = $clog2(ETH_MAX_FRAME_SIZE / 8) + 1;

    logic                          rd_valid;
    logic                          rd_ready;
    logic [ETH_MAX_FRAME_SIZE-1:0] rd_data;
    logic [LEN_W-1:0]              rd_len;

    modport master (
        input  rd_valid,
        output rd_ready,
        output rd_data,
        output rd_len
    );

    modport slave (
        output rd_valid,
        input  rd_ready,
        input  rd_data,
        input  rd_len
    );

endinterface

// File: rtl/eth_sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module eth_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_r;

    // Count register with saturation at the top value
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {WIDTH{1'b0}};
        end else if (inc && (count_r != {WIDTH{1'b1}})) begin
            count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign count = count_r;

endmodule

// File: rtl/eth_rx_drv.sv
// MII receive front end: strips preamble/SFD, packs nibbles into a single frame
// buffer and offers the finished frame over the rd request/ready channel.
module eth_rx_drv
    import eth_pkg::*;
#(
    parameter int ETH_MAX_FRAME_SIZE = 256,
    parameter int MIN_FRAME_BYTES    = 1,
    parameter int STAT_WIDTH         = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            mii_rxd,
    input  logic                  mii_rx_dv,
    input  logic                  mii_rx_er,
    eth_rx_drv_if.master          rd,
    output logic [STAT_WIDTH-1:0] stat_frames_ok,
    output logic [STAT_WIDTH-1:0] stat_frames_err,
    output logic [STAT_WIDTH-1:0] stat_overrun,
    output logic [2:0]            rx_state
);

    localparam int LEN_W     = $clog2(ETH_MAX_FRAME_SIZE / 8) + 1;
    localparam int NIB_CNT_W = $clog2(ETH_MAX_FRAME_SIZE / 4) + 1;
    localparam int BUF_IDX_W = $clog2(ETH_MAX_FRAME_SIZE);
    localparam logic [NIB_CNT_W-1:0] NIB_LIMIT = NIB_CNT_W'(ETH_MAX_FRAME_SIZE / 4);
    localparam logic [NIB_CNT_W-1:0] MIN_BYTES = NIB_CNT_W'(MIN_FRAME_BYTES);

    rx_state_e                     state_r;
    rx_state_e                     state_nxt_s;
    logic                          frame_avail_r;
    logic [ETH_MAX_FRAME_SIZE-1:0] buf_r;
    logic [LEN_W-1:0]              len_r;
    logic [NIB_CNT_W-1:0]          nib_cnt_r;
    logic [BUF_IDX_W-1:0]          nib_lsb_s;
    logic                          transfer_s;
    logic                          avail_nxt_s;
    logic                          buf_clr_s;
    logic                          nib_wr_s;
    logic                          frame_set_s;
    logic                          err_inc_s;
    logic                          ovr_inc_s;

    assign transfer_s = rd.rd_valid & frame_avail_r;

    // Next-state decode and per-cycle datapath strobes
    always_comb begin
        state_nxt_s = state_r;
        buf_clr_s   = 1'b0;
        nib_wr_s    = 1'b0;
        frame_set_s = 1'b0;
        err_inc_s   = 1'b0;
        ovr_inc_s   = 1'b0;
        // A transfer on this edge frees the buffer for a frame starting now
        avail_nxt_s = frame_avail_r & ~transfer_s;
        nib_lsb_s   = BUF_IDX_W'(nibble_lsb(ETH_MAX_FRAME_SIZE, int'(nib_cnt_r)));
        case (state_r)
            RX_IDLE: begin
                if (!mii_rx_dv) begin
                    state_nxt_s = RX_IDLE;
                end else if (avail_nxt_s) begin
                    state_nxt_s = RX_DISCARD;
                    ovr_inc_s   = 1'b1;
                end else if (mii_rxd == MII_PREAMBLE_NIBBLE) begin
                    state_nxt_s = RX_PREAMBLE;
                end else begin
                    state_nxt_s = RX_DISCARD;
                    err_inc_s   = 1'b1;
                end
            end
            RX_PREAMBLE: begin
                if (!mii_rx_dv) begin
                    state_nxt_s = RX_IDLE;
                    err_inc_s   = 1'b1;
                end else if (mii_rx_er) begin
                    state_nxt_s = RX_DISCARD;
                    err_inc_s   = 1'b1;
                end else if (mii_rxd == MII_PREAMBLE_NIBBLE) begin
                    state_nxt_s = RX_PREAMBLE;
                end else if (mii_rxd == MII_SFD_NIBBLE) begin
                    state_nxt_s = RX_PAYLOAD;
                    buf_clr_s   = 1'b1;
                end else begin
                    state_nxt_s = RX_DISCARD;
                    err_inc_s   = 1'b1;
                end
            end
            RX_PAYLOAD: begin
                if (!mii_rx_dv) begin
                    state_nxt_s = RX_IDLE;
                    if (nib_cnt_r[0] || ((nib_cnt_r >> 1) < MIN_BYTES)) begin
                        err_inc_s = 1'b1;
                    end else begin
                        frame_set_s = 1'b1;
                    end
                end else if (mii_rx_er || (nib_cnt_r == NIB_LIMIT)) begin
                    state_nxt_s = RX_DISCARD;
                    err_inc_s   = 1'b1;
                end else begin
                    nib_wr_s = 1'b1;
                end
            end
            RX_DISCARD: begin
                if (!mii_rx_dv) begin
                    state_nxt_s = RX_IDLE;
                end else begin
                    state_nxt_s = RX_DISCARD;
                end
            end
            default: begin
                state_nxt_s = RX_DISCARD;
            end
        endcase
    end

    // FSM state, hold flag, nibble packing and length capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= RX_DISCARD;
            frame_avail_r <= 1'b0;
            len_r         <= {LEN_W{1'b0}};
            nib_cnt_r     <= {NIB_CNT_W{1'b0}};
            buf_r         <= {ETH_MAX_FRAME_SIZE{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (frame_set_s) begin
                frame_avail_r <= 1'b1;
                len_r         <= LEN_W'(nib_cnt_r >> 1);
            end else if (transfer_s) begin
                frame_avail_r <= 1'b0;
            end
            if (buf_clr_s) begin
                buf_r     <= {ETH_MAX_FRAME_SIZE{1'b0}};
                nib_cnt_r <= {NIB_CNT_W{1'b0}};
            end else if (nib_wr_s) begin
                buf_r[nib_lsb_s +: 4] <= mii_rxd;
                nib_cnt_r             <= nib_cnt_r + {{(NIB_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    eth_sat_counter #(.WIDTH(STAT_WIDTH)) u_cnt_ok (
        .clk   (clk),
        .rst   (rst),
        .inc   (transfer_s),
        .count (stat_frames_ok)
    );

    eth_sat_counter #(.WIDTH(STAT_WIDTH)) u_cnt_err (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_inc_s),
        .count (stat_frames_err)
    );

    eth_sat_counter #(.WIDTH(STAT_WIDTH)) u_cnt_ovr (
        .clk   (clk),
        .rst   (rst),
        .inc   (ovr_inc_s),
        .count (stat_overrun)
    );

    assign rd.rd_ready = frame_avail_r;
    assign rd.rd_data  = buf_r;
    assign rd.rd_len   = len_r;
    assign rx_state    = state_r;

endmodule
